data_mem_responder: RTL and testbench

Data-memory responder on the far side of the core's M-stage data port. It answers the core's address/write-data/write-enable with same-cycle read data and services a word RAM plus a small memory-mapped I/O page. The page holds an LED register, a free-running cycle counter, and a console transmit FIFO drained through a valid/ready byte stream. It sits beside the core in the top level, wired directly to its data-memory outputs and read-data input.

---
 rtl/data_mem_responder_pkg.sv | 29 ++
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder_tx_byte_fifo.sv | 52 +++++
 rtl/data_mem_responder.sv | 110 +++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-memory responder: I/O page tag, register offsets
// and STATUS bit layout.
package dmem_pkg;

    localparam logic [15:0] IO_PAGE = 16'hFFFF;

    // Byte offsets within the I/O page; only bits [3:2] of the address are decoded.
    localparam logic [3:0] CYCLES_OFS  = 4'h0;
    localparam logic [3:0] LEDS_OFS    = 4'h4;
    localparam logic [3:0] TX_DATA_OFS = 4'h8;
    localparam logic [3:0] STATUS_OFS  = 4'hC;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    function automatic logic [31:0] status_word(input logic [3:0] count, input logic ovf,
                                                input logic empty, input logic full);
        logic [31:0] w;
        w = '0;
        w[STATUS_FULL_BIT]                          = full;
        w[STATUS_EMPTY_BIT]                         = empty;
        w[STATUS_OVF_BIT]                           = ovf;
        w[STATUS_COUNT_LSB+3:STATUS_COUNT_LSB]      = count;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-port bus plus the console byte stream seen by the responder.
interface data_mem_responder_if;

    logic        dmem_write;
    logic [31:0] alu_out;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;
    // Byte stream: a byte transfers on every rising edge where tx_valid && tx_ready;
    // tx_data holds while tx_valid is high and tx_ready low; tx_ready never waits on tx_valid.
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output dmem_write, alu_out, dmem_write_data, tx_ready,
        input  dmem_read_data, tx_valid, tx_data
    );

    modport slave (
        input  dmem_write, alu_out, dmem_write_data, tx_ready,
        output dmem_read_data, tx_valid, tx_data
    );

endinterface

// File: rtl/data_mem_responder_tx_byte_fifo.sv
// Console transmit FIFO; a push into a full FIFO succeeds only when a pop frees a slot
// on the same edge.
module tx_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          push_accepted
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_eff;

    assign empty         = (count == '0);
    assign full          = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_eff       = pop && !empty;
    assign push_accepted = push && (!full || pop_eff);
    assign head          = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_accepted) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)       rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_accepted, pop_eff})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_accepted) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus I/O page (CYCLES, LEDS, TX_DATA, STATUS).
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLES counter.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus,
    output logic [15:0]           leds
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              io_sel;
    logic [3:0]        reg_ofs;
    logic [ADDR_W-1:0] word_idx;
    logic              ram_we;
    logic              leds_we;
    logic              tx_push;
    logic              status_we;
    logic              ovf;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              push_accepted;
    logic [31:0]       count_ext;
    logic [31:0]       cycles;
    logic [31:0]       rdata;
    logic [31:0]       ram [2**ADDR_W];
    logic              unused_addr_bits;

    assign io_sel   = (bus.alu_out[31:16] == IO_PAGE);
    assign reg_ofs  = {bus.alu_out[3:2], 2'b00};
    assign word_idx = bus.alu_out[ADDR_W+1:2];

    assign ram_we    = bus.dmem_write && !io_sel;
    assign leds_we   = bus.dmem_write && io_sel && (reg_ofs == LEDS_OFS);
    assign tx_push   = bus.dmem_write && io_sel && (reg_ofs == TX_DATA_OFS);
    assign status_we = bus.dmem_write && io_sel && (reg_ofs == STATUS_OFS);

    always_ff @(posedge clk) begin
        if (ram_we) ram[word_idx] <= bus.dmem_write_data;
    end

    // ovf is sticky until software writes STATUS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= '0;
            ovf  <= 1'b0;
        end else begin
            if (leds_we)                       leds <= bus.dmem_write_data[15:0];
            if (status_we)                     ovf  <= 1'b0;
            else if (tx_push && !push_accepted) ovf <= 1'b1;
        end
    end

    tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (tx_push),
        .push_data     (bus.dmem_write_data[7:0]),
        .pop           (bus.tx_ready),
        .head          (bus.tx_data),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count),
        .push_accepted (push_accepted)
    );

    assign bus.tx_valid = !fifo_empty;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cycles = cycle_cnt;
`else
    assign cycles = 32'h0;
`endif

    assign count_ext = 32'(fifo_count);

    always_comb begin
        rdata = '0;
        if (!io_sel) begin
            rdata = ram[word_idx];
        end else begin
            case (reg_ofs)
                CYCLES_OFS:  rdata = cycles;
                LEDS_OFS:    rdata = {16'b0, leds};
                TX_DATA_OFS: rdata = '0;
                STATUS_OFS:  rdata = status_word(count_ext[3:0], ovf, fifo_empty, fifo_full);
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.dmem_read_data = rdata;

    // Byte-lane and aliased address bits carry no meaning here.
    assign unused_addr_bits = ^{bus.alu_out[1:0], bus.alu_out[15:4]};

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: RAM, LEDS, console FIFO, cycle counter, reset.
module tb_data_mem_responder;

  import dmem_pkg::*;

  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 4;

  localparam logic [31:0] A_CYCLES = 32'hFFFF_0000;
  localparam logic [31:0] A_LEDS   = 32'hFFFF_0004;
  localparam logic [31:0] A_TX     = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] leds;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.dmem_write      = 1'b1;
    bus.alu_out         = addr;
    bus.dmem_write_data = data;
    @(negedge clk);
    bus.dmem_write      = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.alu_out = addr;
    #1;
    check(tag, bus.dmem_read_data, exp);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    @(negedge clk);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      e = exp_q.pop_front();
      check("drain_valid", 32'(bus.tx_valid), 32'h1);
      check("drain_data", 32'(bus.tx_data), 32'(e));
      @(negedge clk);
    end
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] c1;
    bus.dmem_write      = 1'b0;
    bus.alu_out         = 32'h0;
    bus.dmem_write_data = 32'h0;
    bus.tx_ready        = 1'b0;

    // reset state
    #1;
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    load_check("rst_status", A_STATUS, 32'h0000_0002);
    load_check("rst_cycles", A_CYCLES, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // RAM write/read and aliasing
    store(32'h0000_0040, 32'hDEAD_BEEF);
    load_check("ram_rd", 32'h0000_0040, 32'hDEAD_BEEF);
    load_check("ram_alias", 32'h0000_0440, 32'hDEAD_BEEF);
    load_check("ram_byteofs", 32'h0000_0043, 32'hDEAD_BEEF);
    store(32'h0000_0044, 32'h1234_5678);
    load_check("ram_rd2", 32'h0000_0044, 32'h1234_5678);
    load_check("ram_keep", 32'h0000_0040, 32'hDEAD_BEEF);

    // LEDS register
    store(A_LEDS, 32'h1234_ABCD);
    check("leds_out", 32'(leds), 32'h0000_ABCD);
    load_check("leds_rd", A_LEDS, 32'h0000_ABCD);
    load_check("leds_alias", 32'hFFFF_0014, 32'h0000_ABCD);
    load_check("txdata_rd", A_TX, 32'h0);

    // asynchronous reset clears leds without a clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_leds", 32'(leds), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // FIFO fill and overflow
    for (int b = 1; b <= 5; b++) store(A_TX, 32'(b));
    for (int b = 1; b <= 4; b++) exp_q.push_back(8'(b));
    load_check("fill_status", A_STATUS, 32'h0000_0045);
    check("fill_head", 32'(bus.tx_data), 32'h1);
    @(negedge clk);
    #1;
    check("hold_head", 32'(bus.tx_data), 32'h1);
    drain(4);
    #1;
    check("drained_valid", 32'(bus.tx_valid), 32'h0);
    check("drained_data", 32'(bus.tx_data), 32'h0);
    load_check("drained_status", A_STATUS, 32'h0000_0006);
    store(A_STATUS, 32'hFFFF_FFFF);
    load_check("ovf_clr_status", A_STATUS, 32'h0000_0002);

    // full push/pop collision
    for (int b = 1; b <= 4; b++) begin
      store(A_TX, 32'(b));
      exp_q.push_back(8'(b));
    end
    load_check("coll_full", A_STATUS, 32'h0000_0041);
    @(negedge clk);
    bus.tx_ready        = 1'b1;
    bus.dmem_write      = 1'b1;
    bus.alu_out         = A_TX;
    bus.dmem_write_data = 32'h0000_0009;
    #1;
    check("coll_head", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h09);
    @(negedge clk);
    bus.dmem_write = 1'b0;
    bus.tx_ready   = 1'b0;
    load_check("coll_status", A_STATUS, 32'h0000_0041);
    drain(4);
    load_check("coll_empty", A_STATUS, 32'h0000_0002);

    // push into empty FIFO while sink is ready: accepted, nothing pops
    @(negedge clk);
    bus.tx_ready        = 1'b1;
    bus.dmem_write      = 1'b1;
    bus.alu_out         = A_TX;
    bus.dmem_write_data = 32'h0000_0007;
    #1;
    check("empty_push_valid", 32'(bus.tx_valid), 32'h0);
    @(negedge clk);
    bus.dmem_write = 1'b0;
    bus.tx_ready   = 1'b0;
    load_check("empty_push_status", A_STATUS, 32'h0000_0010);
    exp_q.push_back(8'h07);
    drain(1);

    // cycle counter
`ifdef DMEM_CYCLE_COUNTER_EN
    @(negedge clk);
    bus.alu_out = A_CYCLES;
    #1;
    c1 = bus.dmem_read_data;
    repeat (10) @(negedge clk);
    #1;
    check("cyc_delta", bus.dmem_read_data - c1, 32'd10);
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    #1;
    check("cyc_max", bus.dmem_read_data, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check("cyc_wrap", bus.dmem_read_data, 32'h0);
`else
    @(negedge clk);
    c1 = 32'h0;
    load_check("cyc_off_a", A_CYCLES, c1);
    repeat (7) @(negedge clk);
    load_check("cyc_off_b", A_CYCLES, c1);
`endif

    // reset in the middle of a stream
    for (int b = 0; b < 3; b++) store(A_TX, 32'hA1 + 32'(b));
    #1;
    check("mid_valid", 32'(bus.tx_valid), 32'h1);
    check("mid_head", 32'(bus.tx_data), 32'h0000_00A1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("mid_rst_data", 32'(bus.tx_data), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    load_check("mid_rst_status", A_STATUS, 32'h0000_0002);
    exp_q.delete();

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
